// File: rtl/pc_predict_unit.sv
// Fetch PC unit with speculative next-PC selection and EX-driven mispredict recovery.
// Define PC_PREDICT_BTB_EN to add the direct-mapped BTB with 2-bit counters; otherwise static not-taken.
module pc_predict_unit #(
    parameter int              SIZE         = 32,
    parameter int              BTB_ENTRIES  = 16,
    parameter logic [SIZE-1:0] RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stallF,
    input  logic            Jump,
    input  logic            Branch,
    input  logic            result,
    input  logic [SIZE-1:0] ex_pc,
    input  logic [SIZE-1:0] pc_target,
    input  logic            ex_pred_taken,
    input  logic [SIZE-1:0] ex_pred_target,
    output logic [SIZE-1:0] pc,
    output logic [SIZE-1:0] pc_plus4,
    output logic            pred_taken,
    output logic [SIZE-1:0] pred_target,
    output logic            PCSE
);

    localparam logic [SIZE-1:0] PC_STEP = {{(SIZE-3){1'b0}}, 3'd4};

    logic [SIZE-1:0] pc_r;
    logic [SIZE-1:0] pc_plus4_s;
    logic            resolve_s;
    logic            actual_s;
    logic            mispredict_s;
    logic [SIZE-1:0] recovery_s;
    logic            pred_taken_s;
    logic [SIZE-1:0] pred_target_s;

    assign pc_plus4_s = pc_r + PC_STEP;
    assign resolve_s  = Jump | Branch;
    assign actual_s   = Jump | (Branch & result);

    // Recovery target for a resolved instruction: its target when taken, its fall-through otherwise.
    always_comb begin
        recovery_s = ex_pc + PC_STEP;
        if (actual_s) begin
            recovery_s = pc_target;
        end else begin
            recovery_s = ex_pc + PC_STEP;
        end
    end

`ifdef PC_PREDICT_BTB_EN
    localparam int IDX   = $clog2(BTB_ENTRIES);
    localparam int TAG_W = SIZE - IDX - 2;

    logic [BTB_ENTRIES-1:0] valid_r;
    logic [TAG_W-1:0]       tag_r    [BTB_ENTRIES];
    logic [SIZE-1:0]        target_r [BTB_ENTRIES];
    logic [1:0]             ctr_r    [BTB_ENTRIES];

    logic [IDX-1:0]   f_idx_s;
    logic [TAG_W-1:0] f_tag_s;
    logic             f_hit_s;
    logic [IDX-1:0]   e_idx_s;
    logic [TAG_W-1:0] e_tag_s;
    logic             e_hit_s;

    function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
        logic [1:0] nxt;
        case ({up, ctr})
            3'b1_11: nxt = 2'b11;
            3'b0_00: nxt = 2'b00;
            3'b1_00, 3'b1_01, 3'b1_10: nxt = ctr + 2'b01;
            3'b0_01, 3'b0_10, 3'b0_11: nxt = ctr - 2'b01;
            default: nxt = ctr;
        endcase
        return nxt;
    endfunction

    assign f_idx_s = pc_r[IDX+1:2];
    assign f_tag_s = pc_r[SIZE-1:IDX+2];
    assign e_idx_s = ex_pc[IDX+1:2];
    assign e_tag_s = ex_pc[SIZE-1:IDX+2];
    assign f_hit_s = valid_r[f_idx_s] & (tag_r[f_idx_s] == f_tag_s);
    assign e_hit_s = valid_r[e_idx_s] & (tag_r[e_idx_s] == e_tag_s);

    // Fetch-side prediction for the current PC.
    always_comb begin
        pred_taken_s  = f_hit_s & ctr_r[f_idx_s][1];
        pred_target_s = pc_plus4_s;
        if (pred_taken_s) begin
            pred_target_s = target_r[f_idx_s];
        end else begin
            pred_target_s = pc_plus4_s;
        end
    end

    // Wrong direction, or right "taken" direction with a stale target.
    always_comb begin
        mispredict_s = 1'b0;
        if (resolve_s) begin
            mispredict_s = (actual_s != ex_pred_taken) |
                           (actual_s & ex_pred_taken & (pc_target != ex_pred_target));
        end else begin
            mispredict_s = 1'b0;
        end
    end

    // Valid bits: cleared on reset, set when a taken miss allocates an entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else if (resolve_s && !e_hit_s && actual_s) begin
            valid_r[e_idx_s] <= 1'b1;
        end
    end

    // Tag/target/counter storage; contents are meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (!rst && resolve_s) begin
            if (e_hit_s) begin
                target_r[e_idx_s] <= pc_target;
                ctr_r[e_idx_s]    <= Jump ? 2'b11 : ctr_step(ctr_r[e_idx_s], actual_s);
            end else if (actual_s) begin
                tag_r[e_idx_s]    <= e_tag_s;
                target_r[e_idx_s] <= pc_target;
                ctr_r[e_idx_s]    <= Jump ? 2'b11 : 2'b10;
            end
        end
    end
`else
    logic unused_s;

    assign unused_s      = ^{ex_pred_taken, ex_pred_target};
    assign pred_taken_s  = 1'b0;
    assign pred_target_s = pc_plus4_s;

    // Static not-taken: every taken resolution is a redirect.
    always_comb begin
        mispredict_s = 1'b0;
        if (resolve_s) begin
            mispredict_s = actual_s;
        end else begin
            mispredict_s = 1'b0;
        end
    end
`endif

    // Next fetch PC: reset, redirect (beats stall), stall, then predicted next PC.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r <= RESET_VECTOR;
        end else if (mispredict_s) begin
            pc_r <= recovery_s;
        end else if (stallF) begin
            pc_r <= pc_r;
        end else begin
            pc_r <= pred_target_s;
        end
    end

    assign pc          = pc_r;
    assign pc_plus4    = pc_plus4_s;
    assign pred_taken  = pred_taken_s;
    assign pred_target = pred_target_s;
    assign PCSE        = mispredict_s;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed scoreboard bench for pc_predict_unit (4-entry BTB, reset vector 0x100).
module tb_pc_predict_unit;

`ifdef PC_PREDICT_BTB_EN
    localparam bit BTB = 1'b1;
`else
    localparam bit BTB = 1'b0;
`endif

    localparam int K_PC = 0, K_P4 = 1, K_PT = 2, K_PTG = 3, K_SE = 4;

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } item_t;

    logic        clk = 1'b0;
    logic        rst, stallF, Jump, Branch, result, ex_pred_taken;
    logic [31:0] ex_pc, pc_target, ex_pred_target;
    logic [31:0] pc, pc_plus4, pred_target;
    logic        pred_taken, PCSE;

    item_t sb[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    pc_predict_unit #(
        .SIZE(32), .BTB_ENTRIES(4), .RESET_VECTOR(32'h0000_0100)
    ) dut (
        .clk(clk), .rst(rst), .stallF(stallF), .Jump(Jump), .Branch(Branch),
        .result(result), .ex_pc(ex_pc), .pc_target(pc_target),
        .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
        .pc(pc), .pc_plus4(pc_plus4), .pred_taken(pred_taken),
        .pred_target(pred_target), .PCSE(PCSE)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Jump = 1'b0; Branch = 1'b0; result = 1'b0; ex_pred_taken = 1'b0;
        ex_pc = 32'h0; pc_target = 32'h0; ex_pred_target = 32'h0;
    endtask

    task automatic expect_v(input string name, input int kind, input logic [31:0] v);
        item_t it;
        it.name = name; it.kind = kind; it.exp = v;
        sb.push_back(it);
    endtask

    task automatic drain();
        item_t       it;
        logic [31:0] obs;
        #1;
        while (sb.size() > 0) begin
            it = sb.pop_front();
            case (it.kind)
                K_PC:    obs = pc;
                K_P4:    obs = pc_plus4;
                K_PT:    obs = {31'd0, pred_taken};
                K_PTG:   obs = pred_target;
                K_SE:    obs = {31'd0, PCSE};
                default: obs = 32'hxxxx_xxxx;
            endcase
            n_tests++;
            assert (obs === it.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", it.name, obs, it.exp);
            end
        end
    endtask

    task automatic resolve(input logic j, input logic b, input logic r, input logic [31:0] epc,
                           input logic [31:0] tgt, input logic ept, input logic [31:0] eptg);
        Jump = j; Branch = b; result = r; ex_pc = epc; pc_target = tgt;
        ex_pred_taken = ept; ex_pred_target = eptg;
    endtask

    // Redirect the fetch PC to addr with a mispredicted jump from 0x0FC (a BTB slot no test uses).
    task automatic anchor(input logic [31:0] addr);
        resolve(1'b1, 1'b0, 1'b0, 32'h0000_00FC, addr, 1'b0, 32'h0000_0100);
        expect_v("anchor_pcse", K_SE, 32'd1);
        drain();
        tick();
        idle();
        expect_v("anchor_pc", K_PC, addr);
        drain();
    endtask

    initial begin
        rst = 1'b1; stallF = 1'b0;
        idle();
        tick();
        tick();
        rst = 1'b0;
        expect_v("rst_pc", K_PC, 32'h100);
        expect_v("rst_pc4", K_P4, 32'h104);
        expect_v("rst_pt", K_PT, 32'd0);
        expect_v("rst_ptg", K_PTG, 32'h104);
        expect_v("rst_pcse", K_SE, 32'd0);
        drain();
        for (int i = 1; i < 4; i++) begin
            tick();
            expect_v("seq_pc", K_PC, 32'h100 + 32'(4 * i));
            expect_v("seq_pt", K_PT, 32'd0);
            drain();
        end

        // Taken branch at 0x108 predicted not-taken.
        resolve(1'b0, 1'b1, 1'b1, 32'h108, 32'h200, 1'b0, 32'h10C);
        expect_v("br_pcse", K_SE, 32'd1);
        drain();
        tick();
        idle();
        expect_v("br_redirect_pc", K_PC, 32'h200);
        drain();
        anchor(32'h108);
        expect_v("revisit_pt", K_PT, BTB ? 32'd1 : 32'd0);
        expect_v("revisit_ptg", K_PTG, BTB ? 32'h200 : 32'h10C);
        drain();
        tick();
        expect_v("revisit_next_pc", K_PC, BTB ? 32'h200 : 32'h10C);
        drain();

        // Train to 11, then two not-taken resolutions predicted taken.
        resolve(1'b0, 1'b1, 1'b1, 32'h108, 32'h200, 1'b1, 32'h200);
        expect_v("train_pcse", K_SE, BTB ? 32'd0 : 32'd1);
        drain();
        tick();
        idle();
        anchor(32'h400);
        expect_v("miss_pt", K_PT, 32'd0);
        drain();
        resolve(1'b0, 1'b1, 1'b0, 32'h108, 32'h200, 1'b1, 32'h200);
        expect_v("nt1_pcse", K_SE, BTB ? 32'd1 : 32'd0);
        drain();
        tick();
        expect_v("nt1_pc", K_PC, BTB ? 32'h10C : 32'h404);
        expect_v("nt2_pcse", K_SE, BTB ? 32'd1 : 32'd0);
        drain();
        tick();
        idle();
        expect_v("nt2_pc", K_PC, BTB ? 32'h10C : 32'h408);
        drain();
        anchor(32'h108);
        expect_v("weak_pt", K_PT, 32'd0);
        expect_v("weak_ptg", K_PTG, 32'h10C);
        drain();

        // Resolution inputs without Jump/Branch never redirect.
        result = 1'b1; ex_pred_taken = 1'b1;
        expect_v("noresolve_pcse", K_SE, 32'd0);
        drain();
        idle();

        // Stall holds, mispredict overrides the stall.
        anchor(32'h140);
        stallF = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_v("stall_pc", K_PC, 32'h140);
            drain();
        end
        resolve(1'b0, 1'b1, 1'b1, 32'h130, 32'h300, 1'b0, 32'h134);
        expect_v("stall_pcse", K_SE, 32'd1);
        drain();
        tick();
        idle();
        stallF = 1'b0;
        expect_v("stall_override_pc", K_PC, 32'h300);
        drain();

        // Aliasing: 0x004 and 0x014 share index 1.
        resolve(1'b0, 1'b1, 1'b1, 32'h004, 32'h040, 1'b0, 32'h008);
        tick();
        idle();
        expect_v("alloc1_pc", K_PC, 32'h040);
        drain();
        anchor(32'h004);
        expect_v("alias_first_pt", K_PT, BTB ? 32'd1 : 32'd0);
        expect_v("alias_first_ptg", K_PTG, BTB ? 32'h040 : 32'h008);
        drain();
        resolve(1'b0, 1'b1, 1'b1, 32'h014, 32'h080, 1'b0, 32'h018);
        tick();
        idle();
        expect_v("alloc2_pc", K_PC, 32'h080);
        drain();
        anchor(32'h004);
        expect_v("alias_evict_pt", K_PT, 32'd0);
        expect_v("alias_evict_ptg", K_PTG, 32'h008);
        drain();
        anchor(32'h014);
        expect_v("alias_second_pt", K_PT, BTB ? 32'd1 : 32'd0);
        expect_v("alias_second_ptg", K_PTG, BTB ? 32'h080 : 32'h018);
        drain();

        // Right direction, wrong target.
        resolve(1'b0, 1'b1, 1'b1, 32'h014, 32'h090, 1'b1, 32'h080);
        expect_v("tgt_mismatch_pcse", K_SE, 32'd1);
        drain();
        tick();
        idle();
        expect_v("tgt_mismatch_pc", K_PC, 32'h090);
        drain();

        // Mid-stream reset invalidates the BTB.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_v("midrst_pc", K_PC, 32'h100);
        drain();
        anchor(32'h014);
        expect_v("midrst_pt", K_PT, 32'd0);
        expect_v("midrst_ptg", K_PTG, 32'h018);
        drain();

        // PC arithmetic wraps.
        anchor(32'hFFFF_FFFC);
        expect_v("wrap_pc4", K_P4, 32'h0);
        drain();
        tick();
        expect_v("wrap_pc", K_PC, 32'h0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_predict_unit.md
# pc_predict_unit

Fetch-stage program-counter unit with a direct-mapped branch target buffer (BTB) and 2-bit saturating-counter direction prediction. It generalises the plain PC-plus-4/target selector with a configurable width, reset vector and BTB depth, speculative next-PC selection, and misprediction recovery driven by branch resolution in EX. It sits at the front of the pipeline: it feeds the instruction memory address and forwards the prediction down the pipe, and it receives resolution and a flush request back from EX.

## Interface
- SIZE, 32, PC/address width (≥ 8)
- BTB_ENTRIES, 16, BTB depth; power of two, ≥ 2; IDX = log2(BTB_ENTRIES)
- RESET_VECTOR, 32'h0000_0000, PC value after reset

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stallF  in  1  1 = hold PC (no advance)
- Jump  in  1  EX: resolving instruction is an unconditional jump
- Branch  in  1  EX: resolving instruction is a conditional branch
- result  in  1  EX: branch condition outcome (1 = taken)
- ex_pc  in  SIZE  EX: PC of the resolving instruction
- pc_target  in  SIZE  EX: computed target of the resolving instruction
- ex_pred_taken  in  1  EX: prediction carried down the pipe with that instruction
- ex_pred_target  in  SIZE  EX: predicted target carried down the pipe
- pc  out  SIZE  current fetch PC (registered)
- pc_plus4  out  SIZE  pc + 4, modulo 2^SIZE
- pred_taken  out  1  prediction for the instruction at `pc`
- pred_target  out  SIZE  predicted target (equals pc_plus4 when pred_taken = 0)
- PCSE  out  1  mispredict redirect; the pipeline flushes IF/ID

## Operation
- Lookup (combinational on `pc`): idx = pc[IDX+1:2], tag = pc[SIZE-1:IDX+2]. A hit requires valid[idx] and tag match. pred_taken = hit & ctr[idx][1].
- Resolution: actual = Jump | (Branch & result). This is evaluated only when Jump | Branch; otherwise PCSE = 0.
- Misprediction occurs in either case:
  - actual ≠ ex_pred_taken
  - actual & ex_pred_taken & (pc_target ≠ ex_pred_target)
- Recovery target: pc_target if actual, else ex_pc + 4. PCSE = mispredict, combinational.
- Next-PC priority, highest first:
  1. rst → RESET_VECTOR
  2. PCSE → recovery target (overrides stallF)
  3. stallF → hold
  4. pred_taken → pred_target
  5. otherwise pc_plus4
- BTB update, on an edge where Jump | Branch:
  - Hit on ex_pc: store pc_target. Counter increments if actual, decrements if not, saturating at 00 and 11. Jump forces 11.
  - Miss and actual: allocate the entry (valid = 1, tag, target). Counter = 11 for Jump, 10 for Branch.
  - Miss and not actual: no change.
- Reset clears all valid bits. Target and counter contents are don't-care.
- Low two PC bits are never used for indexing or tag. All PC arithmetic wraps modulo 2^SIZE.

## Timing
- `pc` is registered and `pred_*` is combinational from `pc` in the same cycle. There is zero-cycle prediction latency.
- Redirect: PCSE asserted in cycle N → pc = recovery target in cycle N+1.
- A BTB write at edge N becomes visible to lookups from cycle N+1. A same-cycle lookup of the index being written sees the old contents.
- Stall: pc holds for every stall cycle, while BTB updates still occur.
- Reset in the middle of a stream: pc = RESET_VECTOR on the next cycle and the BTB is invalidated. No update is performed on a reset edge.
- Reset values: pc = RESET_VECTOR, pc_plus4 = RESET_VECTOR + 4, pred_taken = 0, pred_target = pc_plus4. PCSE follows its inputs.

## Configuration
- `PC_PREDICT_BTB_EN` defined: BTB and counters are present, with the behaviour above.
- `PC_PREDICT_BTB_EN` undefined:
  - No BTB storage.
  - pred_taken = 0 and pred_target = pc_plus4.
  - Mispredict = actual, so the block behaves as a static not-taken predictor with the same port list.
  - BTB_ENTRIES is ignored.

## Test plan
- Reset with RESET_VECTOR = 0x100, then run 4 cycles with no control inputs → pc = 0x100, 0x104, 0x108, 0x10C. pred_taken = 0 throughout.
- Branch at 0x108 resolves taken to 0x200 with ex_pred_taken = 0 → PCSE = 1 that cycle and pc = 0x200 next cycle. When pc revisits 0x108: pred_taken = 1 and pred_target = 0x200.
- Train 0x108 to counter 11, then resolve not-taken twice with ex_pred_taken = 1 → PCSE = 1 each time and recovery target = 0x10C. After both, pred_taken = 0 at 0x108 (counter 01).
- stallF = 1 for 3 cycles at pc = 0x140 → pc stays 0x140. A mispredict during the stall with target 0x300 → pc = 0x300 next cycle, overriding the stall.
- Aliasing with BTB_ENTRIES = 4: entries at 0x004 and 0x014 share idx 1 → the second allocation evicts the first, and a lookup at 0x004 misses (tag mismatch).
- Build without `PC_PREDICT_BTB_EN`, repeat the second scenario → pred_taken is always 0 and every taken branch asserts PCSE.
